// File: rtl/issue_ctrl_pkg.sv
// Shared types and defaults for the in-order issue controller.
// State encoding, register-file geometry and default pipeline depths.
package issue_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_BR = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  localparam int NREGS         = 32;
  localparam int REG_W         = 5;
  localparam int WB_LAT_DEF    = 4;
  localparam int FLUSH_CYC_DEF = 2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             writes_rd;
    logic             is_branch;
  } dec_req_t;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/issue_ctrl_reg_scoreboard.sv
// Per-register countdown scoreboard: a nonzero counter means a write is
// still in flight; x0 has no counter and is never busy.
module reg_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [REG_W-1:0] ld_idx,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic [NREGS-1:0] busy_mask,
  output logic             rs1_busy,
  output logic             rs2_busy
);

  localparam int             CW     = cnt_w(WB_LAT);
  localparam logic [CW-1:0]  LD_VAL = CW'(WB_LAT);

  assign busy_mask[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic [CW-1:0] cnt_q;

    // A load wins over the decrement, so a WAW reissue restarts the window.
    always_ff @(posedge clk) begin
      if (rst)
        cnt_q <= '0;
      else if (ld_en && ld_idx == REG_W'(i))
        cnt_q <= LD_VAL;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end

    assign busy_mask[i] = (cnt_q != '0);
  end

  assign rs1_busy = busy_mask[rs1];
  assign rs2_busy = busy_mask[rs2];

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller between decode and execute: RAW interlock via
// the scoreboard, branch serialization and wrong-path squash after taken.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int WB_LAT    = WB_LAT_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             writes_rd,
  input  logic             is_branch,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic             issue,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [NREGS-1:0] busy_mask,
  output logic [15:0]      stall_cnt
);

  localparam int            FW      = cnt_w(FLUSH_CYC);
  localparam logic [FW-1:0] FLUSH_LD = FW'(FLUSH_CYC);

  dec_req_t         req;
  state_e           state_q;
  logic [FW-1:0]    flush_ctr_q;
  logic [15:0]      stall_cnt_q;
  logic [NREGS-1:0] busy_raw;
  logic             rs1_busy, rs2_busy;
  logic             hazard;
  logic             sb_ld;

  assign req = '{valid:     instr_valid,
                 rs1:       rs1,
                 rs2:       rs2,
                 rd:        rd,
                 uses_rs1:  uses_rs1,
                 uses_rs2:  uses_rs2,
                 writes_rd: writes_rd,
                 is_branch: is_branch};

  reg_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .ld_en     (sb_ld),
    .ld_idx    (req.rd),
    .rs1       (req.rs1),
    .rs2       (req.rs2),
    .busy_mask (busy_raw),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

  assign hazard = (req.uses_rs1 && req.rs1 != '0 && rs1_busy) ||
                  (req.uses_rs2 && req.rs2 != '0 && rs2_busy);

  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          issue = req.valid && !hazard;
          stall = req.valid && hazard;
        end
        WAIT_BR: stall = req.valid;
        FLUSH:   flush = 1'b1;
        default: ;
      endcase
    end
  end

  // Only real issues reach the scoreboard; squashed slots never have issue set.
  assign sb_ld  = issue && req.writes_rd && req.rd != '0;
  assign bubble = !issue;

  // Registered state may be stale in the reset cycle itself, so mask it.
  assign busy_mask = rst ? '0 : busy_raw;
  assign stall_cnt = rst ? '0 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_ctr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;

      unique case (state_q)
        RUN: begin
          if (issue && req.is_branch)
            state_q <= WAIT_BR;
        end
        WAIT_BR: begin
          if (br_resolve) begin
            if (br_taken && FLUSH_CYC > 0) begin
              state_q     <= FLUSH;
              flush_ctr_q <= FLUSH_LD;
            end else begin
              state_q <= RUN;
            end
          end
        end
        FLUSH: begin
          flush_ctr_q <= flush_ctr_q - 1'b1;
          if (flush_ctr_q <= FW'(1))
            state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed table-driven bench for issue_ctrl: one table row per clock cycle,
// followed by a hand-written stall-counter saturation and reset sequence.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        uses_rs1, uses_rs2, writes_rd, is_branch;
  logic        br_resolve, br_taken;
  logic        issue, stall, bubble, flush;
  logic [31:0] busy_mask;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.WB_LAT(4), .FLUSH_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .uses_rs1   (uses_rs1),
    .uses_rs2   (uses_rs2),
    .writes_rd  (writes_rd),
    .is_branch  (is_branch),
    .br_resolve (br_resolve),
    .br_taken   (br_taken),
    .issue      (issue),
    .stall      (stall),
    .bubble     (bubble),
    .flush      (flush),
    .busy_mask  (busy_mask),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    bit        rst, iv;
    bit [4:0]  rs1, rs2, rd;
    bit        u1, u2, wr, br, res, tk;
    bit        e_iss, e_stl, e_fl;
    bit [31:0] e_busy;
    bit [15:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit r, bit iv, bit [4:0] s1, bit [4:0] s2, bit [4:0] d,
                              bit u1, bit u2, bit wr, bit br, bit res, bit tk,
                              bit e_iss, bit e_stl, bit e_fl, bit [31:0] e_busy,
                              bit [15:0] e_cnt);
    vec_t v;
    v.rst = r; v.iv = iv; v.rs1 = s1; v.rs2 = s2; v.rd = d;
    v.u1 = u1; v.u2 = u2; v.wr = wr; v.br = br; v.res = res; v.tk = tk;
    v.e_iss = e_iss; v.e_stl = e_stl; v.e_fl = e_fl; v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; instr_valid = v.iv; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
    uses_rs1 = v.u1; uses_rs2 = v.u2; writes_rd = v.wr; is_branch = v.br;
    br_resolve = v.res; br_taken = v.tk;
  endtask

  task automatic check(input string nm, input bit e_iss, input bit e_stl, input bit e_fl,
                       input bit [31:0] e_busy, input bit [15:0] e_cnt);
    n_vec++;
    if (issue !== e_iss || stall !== e_stl || flush !== e_fl || bubble !== !e_iss ||
        busy_mask !== e_busy || stall_cnt !== e_cnt) begin
      n_bad++;
      $display("FAIL %s: got iss=%b stl=%b fl=%b bub=%b busy=%h cnt=%h, want iss=%b stl=%b fl=%b bub=%b busy=%h cnt=%h",
               nm, issue, stall, flush, bubble, busy_mask, stall_cnt,
               e_iss, e_stl, e_fl, !e_iss, e_busy, e_cnt);
    end
  endtask

  localparam bit [31:0] B3 = 32'h0000_0008;
  localparam bit [31:0] B4 = 32'h0000_0010;
  localparam bit [31:0] B5 = 32'h0000_0020;

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0);
    drive(idle);
    rst = 1'b1;

    //           rst iv rs1 rs2 rd  u1 u2 wr br res tk  iss stl fl busy cnt
    // reset cycles: a valid producer during rst must not issue
    tv.push_back(mk(1,0, 0,0,0,  0,0,0,0,0,0,  0,0,0, 0,  0));
    tv.push_back(mk(1,1, 0,0,5,  0,0,1,0,1,1,  0,0,0, 0,  0));
    // back-to-back RAW on x5: stall 4 cycles, issue in the 5th
    tv.push_back(mk(0,1, 0,0,5,  0,0,1,0,0,0,  1,0,0, 0,  0));
    tv.push_back(mk(0,1, 5,0,0,  1,0,0,0,0,0,  0,1,0, B5, 0));
    tv.push_back(mk(0,1, 5,0,0,  1,0,0,0,0,0,  0,1,0, B5, 1));
    tv.push_back(mk(0,1, 5,0,0,  1,0,0,0,0,0,  0,1,0, B5, 2));
    tv.push_back(mk(0,1, 5,0,0,  1,0,0,0,0,0,  0,1,0, B5, 3));
    tv.push_back(mk(0,1, 5,0,0,  1,0,0,0,0,0,  1,0,0, 0,  4));
    // x0 producer / consumer never busy
    tv.push_back(mk(0,1, 0,0,0,  0,0,1,0,0,0,  1,0,0, 0,  4));
    tv.push_back(mk(0,1, 0,0,0,  1,0,0,0,0,0,  1,0,0, 0,  4));
    // unused rs2 on busy x5 does not stall; used rs2 does
    tv.push_back(mk(0,1, 0,0,5,  0,0,1,0,0,0,  1,0,0, 0,  4));
    tv.push_back(mk(0,1, 0,5,0,  0,0,0,0,0,0,  1,0,0, B5, 4));
    tv.push_back(mk(0,1, 0,5,0,  0,1,0,0,0,0,  0,1,0, B5, 4));
    tv.push_back(mk(0,0, 0,0,0,  0,0,0,0,0,0,  0,0,0, B5, 5));
    // stray resolve in RUN is ignored
    tv.push_back(mk(0,0, 0,0,0,  0,0,0,0,1,1,  0,0,0, B5, 5));
    tv.push_back(mk(0,1, 0,0,0,  0,0,0,0,0,0,  1,0,0, 0,  5));
    // taken branch: wait 3, flush 2, squashed write to x7 leaves no trace
    tv.push_back(mk(0,1, 0,0,0,  0,0,0,1,0,0,  1,0,0, 0,  5));
    tv.push_back(mk(0,1, 0,0,7,  0,0,1,0,0,0,  0,1,0, 0,  5));
    tv.push_back(mk(0,1, 0,0,7,  0,0,1,0,0,0,  0,1,0, 0,  6));
    tv.push_back(mk(0,1, 0,0,7,  0,0,1,0,1,1,  0,1,0, 0,  7));
    tv.push_back(mk(0,1, 0,0,7,  0,0,1,0,0,0,  0,0,1, 0,  8));
    tv.push_back(mk(0,1, 0,0,7,  0,0,1,0,0,0,  0,0,1, 0,  8));
    tv.push_back(mk(0,1, 7,0,0,  1,0,0,0,0,0,  1,0,0, 0,  8));
    // not-taken branch: resolve in cycle 2, issue in cycle 3
    tv.push_back(mk(0,1, 0,0,0,  0,0,0,1,0,0,  1,0,0, 0,  8));
    tv.push_back(mk(0,1, 0,0,0,  0,0,0,0,0,0,  0,1,0, 0,  8));
    tv.push_back(mk(0,1, 0,0,0,  0,0,0,0,1,0,  0,1,0, 0,  9));
    tv.push_back(mk(0,1, 0,0,0,  0,0,0,0,0,0,  1,0,0, 0,  10));
    // reset in WAIT_BR with x3/x9 busy, resolve in the same cycle
    tv.push_back(mk(0,1, 0,0,3,  0,0,1,0,0,0,  1,0,0, 0,  10));
    tv.push_back(mk(0,1, 0,0,9,  0,0,1,1,0,0,  1,0,0, B3, 10));
    tv.push_back(mk(1,1, 3,0,0,  1,0,0,0,1,1,  0,0,0, 0,  0));
    tv.push_back(mk(0,1, 3,0,0,  1,0,0,0,0,0,  1,0,0, 0,  0));
    // WAW on x4: reload at cycle 2, busy through cycle 6, clear at 7
    tv.push_back(mk(0,1, 0,0,4,  0,0,1,0,0,0,  1,0,0, 0,  0));
    tv.push_back(mk(0,0, 0,0,0,  0,0,0,0,0,0,  0,0,0, B4, 0));
    tv.push_back(mk(0,1, 0,0,4,  0,0,1,0,0,0,  1,0,0, B4, 0));
    tv.push_back(mk(0,0, 0,0,0,  0,0,0,0,0,0,  0,0,0, B4, 0));
    tv.push_back(mk(0,0, 0,0,0,  0,0,0,0,0,0,  0,0,0, B4, 0));
    tv.push_back(mk(0,0, 0,0,0,  0,0,0,0,0,0,  0,0,0, B4, 0));
    tv.push_back(mk(0,0, 0,0,0,  0,0,0,0,0,0,  0,0,0, B4, 0));
    tv.push_back(mk(0,0, 0,0,0,  0,0,0,0,0,0,  0,0,0, 0,  0));

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      drive(tv[i]);
      #4;
      check($sformatf("vec%0d", i), tv[i].e_iss, tv[i].e_stl, tv[i].e_fl,
            tv[i].e_busy, tv[i].e_cnt);
    end

    // Saturation: issue a branch, never resolve it, keep decode valid.
    @(posedge clk); #1;
    drive(mk(0,1, 0,0,0, 0,0,0,1,0,0, 0,0,0,0,0));
    #4;
    check("sat_br_issue", 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(mk(0,1, 0,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
    repeat (70000) @(posedge clk);
    #5;
    check("sat_hold", 0, 1, 0, 0, 16'hFFFF);
    @(posedge clk); #5;
    check("sat_hold2", 0, 1, 0, 0, 16'hFFFF);

    // Reset clears the counter and drops out of WAIT_BR.
    @(posedge clk); #1;
    rst = 1'b1;
    #4;
    check("sat_rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    check("post_rst_issue", 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
